// File: rtl/ahb_mem_fifo_pkg.sv
// Shared encodings, FSM state type and command-word layout for the AHB-to-FIFO front end.
// Latency: none (declarations only).
// Backpressure: n/a.
package ahb_mem_fifo_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_RD,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Command word: {len, write, size, addr}; offsets are relative to the top of addr.
    localparam int CMD_EXTRA_W    = 8;
    localparam int CMD_LEN_W      = 4;
    localparam int CMD_SIZE_OFS   = 0;
    localparam int CMD_WRITE_OFS  = 3;
    localparam int CMD_LEN_OFS    = 4;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int CMD_WIDTH      = ADDR_WIDTH_DEF + CMD_EXTRA_W;

    function automatic int cmd_width(input int addr_width);
        return addr_width + CMD_EXTRA_W;
    endfunction

    function automatic logic size_legal(input logic [2:0] size, input int data_width);
        int bytes;
        bytes = 1 << size;
        return (bytes * 8) <= data_width;
    endfunction

    function automatic logic [CMD_LEN_W-1:0] burst_len(input logic [2:0] hburst);
        logic [CMD_LEN_W-1:0] len;
        case (hburst)
            HBURST_INCR4:  len = 4'd3;
            HBURST_INCR8:  len = 4'd7;
            HBURST_INCR16: len = 4'd15;
            HBURST_SINGLE, HBURST_INCR, HBURST_WRAP4,
            HBURST_WRAP8, HBURST_WRAP16: len = 4'd0;
            default:       len = 4'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ahb_mem_fifo_beat_cnt.sv
// Burst beat tracker: loadable down-counter with zero flag and beat-pending flag.
// Latency: flags update one cycle after load/beat_done/seq_vld.
// Backpressure: none; beat_done is only pulsed when the owning FIFO accepted the beat.
module ahb_mem_fifo_beat_cnt #(
    parameter int LEN_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [LEN_BITS-1:0] load_len,
    input  logic                beat_done,
    input  logic                seq_vld,
    output logic                cnt_zero,
    output logic                beat_pend
);

    logic [LEN_BITS-1:0] cnt_q, cnt_d;
    logic                pend_q, pend_d;

    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (load) begin
            cnt_d  = load_len;
            pend_d = 1'b1;
        end else if (beat_done) begin
            if (cnt_q != '0) begin
                cnt_d  = cnt_q - 1'b1;
                pend_d = seq_vld;
            end else begin
                pend_d = 1'b0;
            end
        end else if (!pend_q) begin
            // BUSY gap: keep looking for the SEQ that resumes the burst
            pend_d = seq_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign cnt_zero  = (cnt_q == '0);
    assign beat_pend = pend_q;

endmodule

// File: rtl/ahb_lite_mem_fifo_burst.sv
// AHB-Lite slave that turns transfers into command/write-data/read-data FIFO traffic; AHB_MEM_FIFO_BURST_EN packs INCR4/8/16 into one command.
// Latency: command pushed the cycle after the address phase, first data beat one cycle later.
// Backpressure: full command/write FIFO or empty read FIFO holds HREADYOUT low.
module ahb_lite_mem_fifo_burst
    import ahb_mem_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_BITS   = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [2:0]            HBURST,
    input  logic                  HSEL,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  CFIFO_WEN,
    output logic [ADDR_WIDTH+7:0] CFIFO_WDATA,
    input  logic                  CFIFO_WFULL,
    output logic                  WFIFO_WEN,
    output logic [DATA_WIDTH-1:0] WFIFO_WDATA,
    input  logic                  WFIFO_WFULL,
    output logic                  RFIFO_REN,
    input  logic [DATA_WIDTH-1:0] RFIFO_RDATA,
    input  logic                  RFIFO_REMPTY
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic                  write_q, write_d;
    logic [LEN_BITS-1:0]   len_q, len_d;

    logic start;
    logic beat_done;
    logic addr_phase;
    logic cnt_zero;
    logic beat_pend;

`ifdef AHB_MEM_FIFO_BURST_EN
    logic seq_vld;

    assign start   = HSEL & HREADY & (HTRANS == HTRANS_NONSEQ);
    assign seq_vld = HSEL & HREADY & (HTRANS == HTRANS_SEQ);

    ahb_mem_fifo_beat_cnt #(
        .LEN_BITS (LEN_BITS)
    ) u_beat_cnt (
        .clk       (HCLK),
        .rst       (HRESET),
        .load      (CFIFO_WEN),
        .load_len  (len_q),
        .beat_done (beat_done),
        .seq_vld   (seq_vld),
        .cnt_zero  (cnt_zero),
        .beat_pend (beat_pend)
    );
`else
    logic hburst_unused;

    // Every beat is its own single-beat command.
    assign start         = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign cnt_zero      = 1'b1;
    assign beat_pend     = 1'b1;
    assign hburst_unused = ^HBURST;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        len_d      = len_q;
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        CFIFO_WEN  = 1'b0;
        WFIFO_WEN  = 1'b0;
        RFIFO_REN  = 1'b0;
        beat_done  = 1'b0;
        addr_phase = 1'b0;

        case (state_q)
            ST_IDLE: addr_phase = 1'b1;
            ST_CMD: begin
                HREADYOUT = 1'b0;
                CFIFO_WEN = !CFIFO_WFULL;
                if (!CFIFO_WFULL) begin
                    state_d = write_q ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                if (beat_pend) begin
                    WFIFO_WEN = !WFIFO_WFULL;
                    HREADYOUT = !WFIFO_WFULL;
                    beat_done = !WFIFO_WFULL;
                end
            end
            ST_RD: begin
                if (beat_pend) begin
                    RFIFO_REN = !RFIFO_REMPTY;
                    HREADYOUT = !RFIFO_REMPTY;
                    beat_done = !RFIFO_REMPTY;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP      = 1'b1;
                addr_phase = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Last beat doubles as the next address phase, so back-to-back starts skip IDLE.
        if (beat_done && cnt_zero) begin
            addr_phase = 1'b1;
        end

        if (addr_phase) begin
            state_d = ST_IDLE;
            if (start) begin
                addr_d  = HADDR;
                size_d  = HSIZE;
                write_d = HWRITE;
`ifdef AHB_MEM_FIFO_BURST_EN
                len_d   = LEN_BITS'(burst_len(HBURST));
`else
                len_d   = '0;
`endif
                state_d = size_legal(HSIZE, DATA_WIDTH) ? ST_CMD : ST_ERR1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        CFIFO_WDATA                                       = '0;
        CFIFO_WDATA[ADDR_WIDTH-1:0]                       = addr_q;
        CFIFO_WDATA[ADDR_WIDTH+CMD_SIZE_OFS +: 3]         = size_q;
        CFIFO_WDATA[ADDR_WIDTH+CMD_WRITE_OFS]             = write_q;
        CFIFO_WDATA[ADDR_WIDTH+CMD_LEN_OFS +: LEN_BITS]   = len_q;
    end

    assign HRDATA      = RFIFO_RDATA;
    assign WFIFO_WDATA = HWDATA;

endmodule

// File: tb/tb_ahb_lite_mem_fifo_burst.sv
// Directed bench: a small pipelined AHB master replays address-phase tables and logs FIFO traffic per cycle.
// Latency/backpressure expectations are hand-computed per scenario.
module tb_ahb_lite_mem_fifo_burst;
    import ahb_mem_fifo_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LB   = 4;
    localparam int NLOG = 24;
`ifdef AHB_MEM_FIFO_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif
    localparam int GAP_K = BURST_EN ? 4 : 5;

    logic          hclk = 1'b0;
    logic          hreset;
    logic [AW-1:0] haddr;
    logic [2:0]    hburst, hsize;
    logic          hsel, hwrite, hready;
    logic [1:0]    htrans;
    logic [DW-1:0] hwdata, hrdata, wfifo_wdata, rfifo_rdata;
    logic          hreadyout, hresp;
    logic          cfifo_wen, cfifo_wfull, wfifo_wen, wfifo_wfull, rfifo_ren, rfifo_rempty;
    logic [AW+7:0] cfifo_wdata;

    always #5 hclk = ~hclk;
    assign hready = hreadyout;

    ahb_lite_mem_fifo_burst #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_BITS   (LB)
    ) dut (
        .HCLK         (hclk),
        .HRESET       (hreset),
        .HADDR        (haddr),
        .HBURST       (hburst),
        .HSEL         (hsel),
        .HSIZE        (hsize),
        .HTRANS       (htrans),
        .HWDATA       (hwdata),
        .HWRITE       (hwrite),
        .HREADY       (hready),
        .HRDATA       (hrdata),
        .HREADYOUT    (hreadyout),
        .HRESP        (hresp),
        .CFIFO_WEN    (cfifo_wen),
        .CFIFO_WDATA  (cfifo_wdata),
        .CFIFO_WFULL  (cfifo_wfull),
        .WFIFO_WEN    (wfifo_wen),
        .WFIFO_WDATA  (wfifo_wdata),
        .WFIFO_WFULL  (wfifo_wfull),
        .RFIFO_REN    (rfifo_ren),
        .RFIFO_RDATA  (rfifo_rdata),
        .RFIFO_REMPTY (rfifo_rempty)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Address-phase table replayed by the master
    logic [1:0]    ph_trans [8];
    logic [AW-1:0] ph_addr  [8];
    logic          ph_write [8];
    logic [2:0]    ph_size  [8];
    logic [2:0]    ph_burst [8];
    logic [DW-1:0] ph_wdata [8];
    int            n_ph;

    logic                 cmd_log  [NLOG];
    logic [CMD_WIDTH-1:0] cmdd_log [NLOG];
    logic                 wen_log  [NLOG];
    logic [DW-1:0]        wdat_log [NLOG];
    logic                 ren_log  [NLOG];
    logic [DW-1:0]        rdat_log [NLOG];
    logic                 rdy_log  [NLOG];
    logic                 resp_log [NLOG];
    int n_cmd, n_wen, n_ren;

    task automatic set_ph(input int i, input logic [1:0] t, input logic [AW-1:0] a, input logic w,
                          input logic [2:0] s, input logic [2:0] b, input logic [DW-1:0] d);
        ph_trans[i] = t; ph_addr[i] = a; ph_write[i] = w;
        ph_size[i]  = s; ph_burst[i] = b; ph_wdata[i] = d;
    endtask

    task automatic run(input int ncyc, input int empty_cycles);
        int   a;
        int   d;
        logic rdy;
        a = 0; d = -1; n_cmd = 0; n_wen = 0; n_ren = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (a < n_ph) begin
                hsel = 1'b1; htrans = ph_trans[a]; haddr = ph_addr[a];
                hwrite = ph_write[a]; hsize = ph_size[a]; hburst = ph_burst[a];
            end else begin
                hsel = 1'b0; htrans = HTRANS_IDLE;
            end
            hwdata       = (d >= 0) ? ph_wdata[d] : '0;
            rfifo_rempty = (k < empty_cycles);
            @(negedge hclk);
            cmd_log[k] = cfifo_wen;  cmdd_log[k] = cfifo_wdata;
            wen_log[k] = wfifo_wen;  wdat_log[k] = wfifo_wdata;
            ren_log[k] = rfifo_ren;  rdat_log[k] = hrdata;
            rdy_log[k] = hreadyout;  resp_log[k] = hresp;
            if (cfifo_wen) n_cmd++;
            if (wfifo_wen) n_wen++;
            if (rfifo_ren) n_ren++;
            rdy = hreadyout;
            @(posedge hclk); #1;
            if (rdy) begin
                if (a < n_ph) begin
                    d = ph_trans[a][1] ? a : -1;
                    a++;
                end else begin
                    d = -1;
                end
            end
        end
        chk("run_done", 64'((a == n_ph) && (d < 0)), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        int p;
        int disc;
        hreset = 1'b1; hsel = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hburst = HBURST_SINGLE;
        hsize = 3'd0; hwrite = 1'b0; hwdata = '0; cfifo_wfull = 1'b0; wfifo_wfull = 1'b0;
        rfifo_rempty = 1'b1; rfifo_rdata = 32'h1234_5678;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        chk("rst_rdy",  64'(hreadyout), 64'd1);
        chk("rst_resp", 64'(hresp),     64'd0);
        chk("rst_en",   64'({cfifo_wen, wfifo_wen, rfifo_ren}), 64'd0);
        @(posedge hclk); #1;
        hreset = 1'b0;

        // Single write
        n_ph = 1;
        set_ph(0, HTRANS_NONSEQ, 32'h100, 1'b1, 3'd2, HBURST_SINGLE, 32'hDEAD_BEEF);
        run(6, 0);
        chk("t1_cmd_vld", 64'(cmd_log[1]),  64'd1);
        chk("t1_cmd_dat", 64'(cmdd_log[1]), 64'h0A_0000_0100);
        chk("t1_cmd_rdy", 64'(rdy_log[1]),  64'd0);
        chk("t1_wr_vld",  64'(wen_log[2]),  64'd1);
        chk("t1_wr_dat",  64'(wdat_log[2]), 64'hDEAD_BEEF);
        chk("t1_wr_rdy",  64'(rdy_log[2]),  64'd1);
        chk("t1_resp",    64'(resp_log[2]), 64'd0);
        chk("t1_ncmd",    64'(n_cmd),       64'd1);
        chk("t1_nwr",     64'(n_wen),       64'd1);

        // Read stalled by an empty read FIFO for 5 cycles
        set_ph(0, HTRANS_NONSEQ, 32'h40, 1'b0, 3'd2, HBURST_SINGLE, 32'h0);
        run(9, 5);
        chk("t2_cmd_vld",  64'(cmd_log[1]),  64'd1);
        chk("t2_cmd_dat",  64'(cmdd_log[1]), 64'h02_0000_0040);
        chk("t2_stall_rdy", 64'(rdy_log[4]), 64'd0);
        chk("t2_stall_ren", 64'(ren_log[4]), 64'd0);
        chk("t2_pop",      64'(ren_log[5]),  64'd1);
        chk("t2_pop_rdy",  64'(rdy_log[5]),  64'd1);
        chk("t2_rdata",    64'(rdat_log[5]), 64'h1234_5678);
        chk("t2_npop",     64'(n_ren),       64'd1);
        chk("t2_nwr",      64'(n_wen),       64'd0);

        // INCR4 write with BUSY after the second beat
        n_ph = 5;
        set_ph(0, HTRANS_NONSEQ, 32'h200, 1'b1, 3'd2, HBURST_INCR4, 32'hA0);
        set_ph(1, HTRANS_SEQ,    32'h204, 1'b1, 3'd2, HBURST_INCR4, 32'hA1);
        set_ph(2, HTRANS_BUSY,   32'h208, 1'b1, 3'd2, HBURST_INCR4, 32'h0);
        set_ph(3, HTRANS_SEQ,    32'h208, 1'b1, 3'd2, HBURST_INCR4, 32'hA2);
        set_ph(4, HTRANS_SEQ,    32'h20C, 1'b1, 3'd2, HBURST_INCR4, 32'hA3);
        run(16, 0);
        chk("t3_cmd_dat", 64'(cmdd_log[1]), BURST_EN ? 64'h3A_0000_0200 : 64'h0A_0000_0200);
        chk("t3_ncmd",    64'(n_cmd),       BURST_EN ? 64'd1 : 64'd4);
        chk("t3_nwr",     64'(n_wen),       64'd4);
        chk("t3_busy_gap", 64'(wen_log[GAP_K]), 64'd0);
        p = 0;
        for (int k = 0; k < 16; k++) begin
            if (wen_log[k]) begin
                if (p < 4) chk("t3_wdat", 64'(wdat_log[k]), 64'(32'hA0 + 32'(p)));
                p++;
            end
        end

        // Illegal size: two-cycle ERROR response
        n_ph = 1;
        set_ph(0, HTRANS_NONSEQ, 32'h400, 1'b1, 3'd3, HBURST_SINGLE, 32'h0);
        run(6, 0);
        chk("t4_err1_rdy",  64'(rdy_log[1]),  64'd0);
        chk("t4_err1_resp", 64'(resp_log[1]), 64'd1);
        chk("t4_err2_rdy",  64'(rdy_log[2]),  64'd1);
        chk("t4_err2_resp", 64'(resp_log[2]), 64'd1);
        chk("t4_okay_resp", 64'(resp_log[3]), 64'd0);
        chk("t4_nfifo",     64'(n_cmd + n_wen + n_ren), 64'd0);

        // Write then read at 0x300 with no IDLE bubble
        n_ph = 2;
        set_ph(0, HTRANS_NONSEQ, 32'h300, 1'b1, 3'd2, HBURST_SINGLE, 32'h55AA_55AA);
        set_ph(1, HTRANS_NONSEQ, 32'h300, 1'b0, 3'd2, HBURST_SINGLE, 32'h0);
        run(8, 0);
        chk("t5_wr_vld",  64'(wen_log[2]),  64'd1);
        chk("t5_rcmd",    64'(cmd_log[3]),  64'd1);
        chk("t5_rcmd_dat", 64'(cmdd_log[3]), 64'h02_0000_0300);
        chk("t5_pop",     64'(ren_log[4]),  64'd1);
        chk("t5_ncmd",    64'(n_cmd),       64'd2);

        // Reset while a command is stalled on a full command FIFO
        cfifo_wfull = 1'b1; hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h500;
        hwrite = 1'b1; hsize = 3'd2; hburst = HBURST_SINGLE;
        @(negedge hclk);
        chk("t6_idle_rdy", 64'(hreadyout), 64'd1);
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = HTRANS_IDLE;
        @(negedge hclk);
        chk("t6_cmd_rdy", 64'(hreadyout), 64'd0);
        chk("t6_cmd_wen", 64'(cfifo_wen), 64'd0);
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0; cfifo_wfull = 1'b0;
        @(negedge hclk);
        chk("t6_rst_rdy",  64'(hreadyout), 64'd1);
        chk("t6_rst_resp", 64'(hresp),     64'd0);
        chk("t6_rst_en",   64'({cfifo_wen, wfifo_wen, rfifo_ren}), 64'd0);
        disc = 0;
        repeat (3) begin
            @(negedge hclk);
            if (cfifo_wen) disc++;
        end
        chk("t6_discard", 64'(disc), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
